// File: rtl/ohc_rns_pkg.sv
// Shared types and helpers for one-hot residue (RNS) channels.
// Mod-9 constants plus a popcount validity check usable by any channel width.
package ohc_rns_pkg;

  localparam int MOD9   = 9;
  localparam int W_OHC9 = 9;
  localparam int W_BIN9 = 4;

  localparam logic [3:0] ERR_CODE = 4'hF;

  typedef logic [W_OHC9-1:0] ohc9_t;

  // Channels up to 16 wide zero-extend into this.
  function automatic logic [4:0] ohc_popcount(
    input logic [15:0] w
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(w[i]);
    end
    return n;
  endfunction

  function automatic logic ohc_valid(
    input logic [15:0] w
  );
    return ohc_popcount(w) == 5'd1;
  endfunction

endpackage

// File: rtl/ohc_decode_core.sv
// Combinational one-hot to binary decode with illegal-word flag.
// Width-generic so the mod-5/mod-7 channels can reuse it.
module ohc_decode_core
  import ohc_rns_pkg::*;
#(
  parameter int MOD          = MOD9,
  parameter int W_BIN        = W_BIN9,
  parameter int ZERO_IS_RES0 = 1
) (
  input  logic [MOD-1:0]   ohc,
  output logic [W_BIN-1:0] bin,
  output logic             err
);

  localparam logic [W_BIN-1:0] ERR_BIN = W_BIN'(ERR_CODE);

  logic [W_BIN-1:0] idx;
  logic             zero;
  logic             hot;

  always_comb begin
    idx = '0;
    for (int i = 0; i < MOD; i++) begin
      if (ohc[i]) idx = W_BIN'(i);
    end
  end

  assign zero = (ohc == '0);
  assign hot  = ohc_valid(16'(ohc));

  always_comb begin
    bin = ERR_BIN;
    err = 1'b1;
    unique case (1'b1)
      zero: begin
        if (ZERO_IS_RES0 != 0) begin
          bin = '0;
          err = 1'b0;
        end
      end
      hot: begin
        bin = idx;
        err = 1'b0;
      end
      default: begin
        bin = ERR_BIN;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ohc9_to_binary_dec.sv
// Two-stage valid/ready decoder from mod-9 one-hot residue to binary,
// with sticky error flag and saturating illegal-word counter.
module ohc9_to_binary_dec
  import ohc_rns_pkg::*;
#(
  parameter int MOD          = MOD9,
  parameter int W_BIN        = W_BIN9,
  parameter int ERR_CNT_W    = 8,
  parameter int ZERO_IS_RES0 = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MOD-1:0]       in_ohc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W_BIN-1:0]     out_bin,
  output logic                 out_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  logic             s1_valid;
  logic [MOD-1:0]   s1_ohc;
  logic             s1_ready;
  logic             s2_ready;
  logic [W_BIN-1:0] dec_bin;
  logic             dec_err;
  logic             xfer_err;

  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;
  assign xfer_err = out_valid && out_ready && out_err;

  ohc_decode_core #(
    .MOD          (MOD),
    .W_BIN        (W_BIN),
    .ZERO_IS_RES0 (ZERO_IS_RES0)
  ) u_dec (
    .ohc (s1_ohc),
    .bin (dec_bin),
    .err (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ohc   <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_ohc <= in_ohc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_bin <= dec_bin;
        out_err <= dec_err;
      end
    end
  end

  // A new error event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (xfer_err) begin
      err_sticky <= 1'b1;
      if (clr_err) begin
        err_count <= ERR_CNT_W'(1);
      end else if (err_count != '1) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end else if (clr_err) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end
  end

endmodule

// File: tb/tb_ohc9_to_binary_dec.sv
// Randomized and directed bench for ohc9_to_binary_dec.
// Three instances share stimulus: default, zero-illegal, 2-bit counter.
module tb_ohc9_to_binary_dec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [8:0] in_ohc = '0;

  logic       r1, r0, rs;
  logic       v1, v0, vs;
  logic [3:0] b1, b0, bs;
  logic       e1, e0, es;
  logic       s1, s0, ss;
  logic [7:0] c1, c0;
  logic [1:0] cs;

  int total = 0;
  int bad = 0;
  bit sb_on = 1'b0;

  always #5 clk = ~clk;

  ohc9_to_binary_dec #(.ERR_CNT_W(8), .ZERO_IS_RES0(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
    .in_ohc(in_ohc), .out_valid(v1), .out_ready(out_ready),
    .out_bin(b1), .out_err(e1), .err_sticky(s1), .err_count(c1),
    .clr_err(clr_err));

  ohc9_to_binary_dec #(.ERR_CNT_W(8), .ZERO_IS_RES0(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0),
    .in_ohc(in_ohc), .out_valid(v0), .out_ready(out_ready),
    .out_bin(b0), .out_err(e0), .err_sticky(s0), .err_count(c0),
    .clr_err(clr_err));

  ohc9_to_binary_dec #(.ERR_CNT_W(2), .ZERO_IS_RES0(1)) ds (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rs),
    .in_ohc(in_ohc), .out_valid(vs), .out_ready(out_ready),
    .out_bin(bs), .out_err(es), .err_sticky(ss), .err_count(cs),
    .clr_err(clr_err));

  // Reference decode straight from the code rules.
  function automatic void ref_dec(input logic [8:0] w, input bit z1,
                                  output logic [3:0] b, output logic e);
    int n;
    n = $countones(w);
    b = 4'hF;
    e = 1'b1;
    if (n == 1) begin
      for (int i = 0; i < 9; i++)
        if (w == (9'h001 << i)) b = 4'(i);
      e = 1'b0;
    end else if (n == 0 && z1) begin
      b = 4'h0;
      e = 1'b0;
    end
  endfunction

  localparam int CMAX[3] = '{255, 255, 3};
  localparam bit ZR[3]   = '{1'b1, 1'b0, 1'b1};

  logic [8:0] q[$];
  int         m_cnt[3] = '{0, 0, 0};
  bit         m_st[3]  = '{0, 0, 0};
  logic [3:0] ab[3];
  logic       ae[3];
  logic [7:0] ac[3];
  logic       as_[3];
  bit         ev[3];
  logic [8:0] mw;
  logic [3:0] rb;
  logic       re;

  // Scoreboard: inputs are stable around negedge, so sample transfers here.
  always @(negedge clk) begin
    if (sb_on) begin
      ab  = '{b1, b0, bs};
      ae  = '{e1, e0, es};
      ac  = '{c1, c0, 8'(cs)};
      as_ = '{s1, s0, ss};
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ac[k] !== 8'(m_cnt[k]) || as_[k] !== m_st[k]) begin
          bad++;
          $display("FAIL err_state dut%0d: got cnt=%0d st=%b want cnt=%0d st=%b",
                   k, ac[k], as_[k], m_cnt[k], m_st[k]);
        end
      end
      if (rst) begin
        q.delete();
        m_cnt = '{0, 0, 0};
        m_st  = '{0, 0, 0};
      end else begin
        ev = '{0, 0, 0};
        if (v1 && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: got bin=%h want no word", b1);
          end else begin
            mw = q.pop_front();
            for (int k = 0; k < 3; k++) begin
              ref_dec(mw, ZR[k], rb, re);
              ev[k] = re;
              total++;
              if (ab[k] !== rb || ae[k] !== re) begin
                bad++;
                $display("FAIL decode dut%0d w=%h: got %h/%b want %h/%b",
                         k, mw, ab[k], ae[k], rb, re);
              end
            end
          end
        end
        for (int k = 0; k < 3; k++) begin
          if (ev[k]) begin
            m_st[k] = 1'b1;
            if (clr_err) m_cnt[k] = 1;
            else if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
          end else if (clr_err) begin
            m_st[k]  = 1'b0;
            m_cnt[k] = 0;
          end
        end
        if (in_valid && r1) q.push_back(in_ohc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    clr_err = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if (v1 !== 1'b0 || b1 !== 4'h0 || e1 !== 1'b0 ||
        s1 !== 1'b0 || c1 !== 8'h0) begin
      bad++;
      $display("FAIL reset_state: got v=%b b=%h e=%b st=%b c=%0d want all 0",
               v1, b1, e1, s1, c1);
    end
    rst = 1'b0;
    #1;
    total++;
    if (r1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", r1);
    end
    sb_on = 1'b1;
  endtask

  task automatic test_walking();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick();
      in_valid = (c < 9);
      in_ohc = (c < 9) ? 9'(1 << c) : 9'h0;
      #1;
      if (c < 9) begin
        total++;
        if (r1 !== 1'b1) begin
          bad++;
          $display("FAIL walk_ready c=%0d: got %b want 1", c, r1);
        end
      end
      total++;
      if (v1 !== (c >= 2)) begin
        bad++;
        $display("FAIL walk_valid c=%0d: got %b want %b", c, v1, c >= 2);
      end else if (c >= 2) begin
        total++;
        if (b1 !== 4'(c - 2) || e1 !== 1'b0) begin
          bad++;
          $display("FAIL walk_bin c=%0d: got %h/%b want %h/0",
                   c, b1, e1, 4'(c - 2));
        end
      end
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (c1 !== 8'h0) begin
      bad++;
      $display("FAIL walk_errcnt: got %0d want 0", c1);
    end
  endtask

  task automatic test_illegal();
    logic [8:0] w[3] = '{9'h003, 9'h180, 9'h000};
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      in_valid = (c < 3);
      in_ohc = (c < 3) ? w[c] : 9'h0;
      if (c == 4) begin
        total++;
        if (b0 !== 4'hF || e0 !== 1'b1 || b1 !== 4'h0 || e1 !== 1'b0) begin
          bad++;
          $display("FAIL zero_word: got z0=%h/%b z1=%h/%b want F/1 0/0",
                   b0, e0, b1, e1);
        end
      end
    end
    total++;
    if (c0 !== 8'd3 || s0 !== 1'b1 || c1 !== 8'd2 || s1 !== 1'b1) begin
      bad++;
      $display("FAIL illegal_cnt: got z0=%0d/%b z1=%0d/%b want 3/1 2/1",
               c0, s0, c1, s1);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] w[4] = '{9'h010, 9'h020, 9'h040, 9'h080};
    logic [3:0] got[$];
    int idx = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick();
      in_valid = (idx < 4);
      in_ohc = (idx < 4) ? w[idx] : 9'h0;
      out_ready = (c >= 4);
      #1;
      if (c == 3) begin
        total++;
        if (idx != 2 || r1 !== 1'b0 || v1 !== 1'b1 || b1 !== 4'd4) begin
          bad++;
          $display("FAIL bp_stall: got acc=%0d rdy=%b v=%b b=%h want 2 0 1 4",
                   idx, r1, v1, b1);
        end
      end
      if (v1 && out_ready) got.push_back(b1);
      if (in_valid && r1) idx++;
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL bp_count: got %0d want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got[k] !== 4'(4 + k)) begin
          bad++;
          $display("FAIL bp_order k=%0d: got %h want %h", k, got[k], 4'(4 + k));
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      in_valid = (c < 5);
      in_ohc = 9'h003;
    end
    total++;
    if (cs !== 2'd3 || ss !== 1'b1 || c1 !== 8'd5) begin
      bad++;
      $display("FAIL sat_cnt: got s=%0d/%b d=%0d want 3/1 5", cs, ss, c1);
    end
    tick();
    in_valid = 1'b1;
    in_ohc = 9'h005;
    tick();
    in_valid = 1'b0;
    tick();
    clr_err = 1'b1;
    total++;
    if (v1 !== 1'b1 || e1 !== 1'b1) begin
      bad++;
      $display("FAIL clr_align: got v=%b e=%b want 1 1", v1, e1);
    end
    tick();
    clr_err = 1'b0;
    total++;
    if (cs !== 2'd1 || ss !== 1'b1 || c1 !== 8'd1) begin
      bad++;
      $display("FAIL clr_vs_err: got s=%0d/%b d=%0d want 1/1 1", cs, ss, c1);
    end
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (cs !== 2'd0 || ss !== 1'b0 || c1 !== 8'd0 || s1 !== 1'b0) begin
      bad++;
      $display("FAIL lone_clr: got s=%0d/%b d=%0d/%b want 0", cs, ss, c1, s1);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    in_ohc = 9'h00C;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    total++;
    if (c1 !== 8'd1 || s1 !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got %0d/%b want 1/1", c1, s1);
    end
    tick();
    in_valid = 1'b1;
    in_ohc = 9'h0C0;
    tick();
    in_ohc = 9'h008;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (v1 !== 1'b0 || b1 !== 4'h0 || e1 !== 1'b0 ||
        c1 !== 8'h0 || s1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b b=%h e=%b c=%0d st=%b want 0",
               v1, b1, e1, c1, s1);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (v1 !== 1'b0) begin
        bad++;
        $display("FAIL mid_stale c=%0d: got v=%b b=%h want v=0", c, v1, b1);
      end
    end
  endtask

  task automatic test_soak();
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      tick();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0, 1: in_ohc = 9'(1 << $urandom_range(0, 8));
        2: in_ohc = 9'h0;
        default: in_ohc = 9'($urandom);
      endcase
    end
    tick();
    in_valid = 1'b0;
    clr_err = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL soak_drain: got %0d words left want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_walking();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
